mmwb_pipe_reg: RTL
==================

// Module: mmwb_pipe_reg
// PURPOSE
//  Parametrised MEM/WB pipeline register for the single- and multi-issue datapaths.
//  Captures LANES memory-stage results per cycle under stall/flush control and tracks per-lane valid.
//  Applies WB hazard masking, captures a sticky halt and counts retired instructions.
//  Sits between the memory stage and the register file.
// PARAMETERS
//  LANES   1   issue lanes captured per cycle; lane 0 is the oldest
//  WORD_W  32  data word width (npc, ALUOut, load, portB)
//  REG_W   5   register index width
//  MTR_W   2   MemtoReg select width
//  CNT_W   32  retired-instruction counter width
// PORTS
//  CLK          in   1              clock, rising edge
//  RST          in   1              synchronous reset, active high
//  en           in   1              capture enable (0 = stall, hold contents)
//  flush        in   1              insert bubble into all lanes
//  in_valid     in   LANES          lane carries a real instruction
//  in_memtoreg  in   LANES*MTR_W    writeback source select
//  in_regwen    in   LANES          register write request
//  in_equal     in   LANES          branch-compare result
//  in_halt      in   LANES          halt instruction
//  in_rd        in   LANES*REG_W    destination register
//  in_portb, in_npc, in_aluout, in_load  in  LANES*WORD_W each; memory-stage data
//  out_valid, out_memtoreg, out_regwen, out_equal, out_rd  out  as in_*; registered
//  out_portb, out_npc, out_aluout, out_load  out  LANES*WORD_W; registered
//  out_wdata    out  LANES*WORD_W   writeback data, combinational mux of the registered fields
//  halt         out  1              sticky halt
//  retired      out  CNT_W          saturating count of retired lanes
// BEHAVIOUR
//  - Reset: every output, halt and retired go to 0 on the first rising edge with RST=1.
//  - Priority on each edge: RST > halt held > flush > en > hold.
//  - Halt held: once halt=1, contents freeze and en/flush are ignored until RST.
//  - Flush: out_valid, out_regwen, out_equal and out_halt-derived state clear to 0.
//    Data fields clear to 0. retired is not incremented.
//  - en=1, no flush: capture all lanes, 1-cycle latency. Per lane i:
//    - v_i = in_valid[i] AND NOT squash_i.
//      squash_i = 1 if some lane j<i has in_valid[j] AND in_halt[j]; younger lanes die behind a halt.
//    - out_regwen[i] = v_i AND in_regwen[i] AND (in_rd[i] != 0).
//    - Same-cycle WAW: if lanes i<j both survive with regwen and equal rd, lane i regwen is cleared.
//      The younger lane wins.
//    - halt sets on this edge if any lane with v_i=1 has in_halt[i]=1.
//    - retired += popcount(v). Saturates at 2^CNT_W-1; no wrap.
//  - en=0, no flush: all registered state holds; retired unchanged.
//  - out_wdata[i] selects by out_memtoreg[i]: 0 = aluout, 1 = load, 2 = npc, 3 = portb.
//    Pure combinational from registered state; valid regardless of out_valid.
//  - RST asserted mid-stall or with halt held: reset still wins; the next cycle is clean.
//  - LANES=1: squash and WAW logic degenerate to no-ops; behaviour equals a plain MEM/WB latch.
// TESTING
//  1. RST=1 for 2 cycles with random inputs -> all outputs 0, halt=0, retired=0.
//  2. LANES=1, en=1, in_valid=1, regwen=1, rd=5, aluout=0xDEADBEEF, memtoreg=0
//     -> next cycle out_regwen=1, out_rd=5, out_wdata=0xDEADBEEF, retired=1.
//  3. Capture as in 2, then en=0 for 3 cycles with changed inputs -> outputs unchanged, retired=1.
//     Then flush=1 -> out_valid=0, out_regwen=0.
//  4. rd=0 with regwen=1 -> out_regwen=0, retired still increments.
//     LANES=2, both lanes rd=7 regwen=1 -> lane0 regwen=0, lane1 regwen=1.
//  5. LANES=2, lane0 halt=1, both valid -> lane1 valid=0, halt=1, retired+=1.
//     Later en=1/flush=1 -> no change. RST=1 -> halt=0.
//  6. CNT_W=4, retired at 14, LANES=2 capture of 2 valid lanes -> retired=15.
//     Next capture -> retired stays 15.

Source files
------------

// File: rtl/mmwb_pipe_reg_if.sv
// MEM/WB pipeline register bus: memory-stage inputs, stall/flush control and
// the registered writeback-side view, including halt and retired count.
interface mmwb_pipe_reg_if #(
  parameter int LANES  = 1,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int MTR_W  = 2,
  parameter int CNT_W  = 32
);
  logic                           en, flush;
  logic [LANES-1:0]               in_valid, in_regwen, in_equal, in_halt;
  logic [LANES-1:0][MTR_W-1:0]    in_memtoreg;
  logic [LANES-1:0][REG_W-1:0]    in_rd;
  logic [LANES-1:0][WORD_W-1:0]   in_portb, in_npc, in_aluout, in_load;
  logic [LANES-1:0]               out_valid, out_regwen, out_equal;
  logic [LANES-1:0][MTR_W-1:0]    out_memtoreg;
  logic [LANES-1:0][REG_W-1:0]    out_rd;
  logic [LANES-1:0][WORD_W-1:0]   out_portb, out_npc, out_aluout, out_load, out_wdata;
  logic                           halt;
  logic [CNT_W-1:0]               retired;

  modport master (
    output en, flush, in_valid, in_regwen, in_equal, in_halt, in_memtoreg, in_rd,
           in_portb, in_npc, in_aluout, in_load,
    input  out_valid, out_regwen, out_equal, out_memtoreg, out_rd,
           out_portb, out_npc, out_aluout, out_load, out_wdata, halt, retired
  );

  modport slave (
    input  en, flush, in_valid, in_regwen, in_equal, in_halt, in_memtoreg, in_rd,
           in_portb, in_npc, in_aluout, in_load,
    output out_valid, out_regwen, out_equal, out_memtoreg, out_rd,
           out_portb, out_npc, out_aluout, out_load, out_wdata, halt, retired
  );
endinterface

// File: rtl/mmwb_pipe_reg.sv
// Multi-lane MEM/WB pipeline register with halt squashing, same-cycle WAW
// masking, sticky halt and a saturating retired-instruction counter.
module mmwb_wb_mux #(
  parameter int WORD_W = 32,
  parameter int MTR_W  = 2
) (
  input  logic [MTR_W-1:0]  sel,
  input  logic [WORD_W-1:0] aluout,
  input  logic [WORD_W-1:0] load,
  input  logic [WORD_W-1:0] npc,
  input  logic [WORD_W-1:0] portb,
  output logic [WORD_W-1:0] wdata
);
  always_comb begin
    case (sel)
      MTR_W'(1): wdata = load;
      MTR_W'(2): wdata = npc;
      MTR_W'(3): wdata = portb;
      default:   wdata = aluout;
    endcase
  end
endmodule

module mmwb_pipe_reg #(
  parameter int LANES  = 1,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int MTR_W  = 2,
  parameter int CNT_W  = 32
) (
  input  logic           CLK,
  input  logic           RST,
  mmwb_pipe_reg_if.slave bus
);
  logic [LANES-1:0]             laneVld, rawWen, laneWen;
  logic                         haltHit, squash;
  logic [CNT_W-1:0]             retiredNxt;
  logic [LANES-1:0][WORD_W-1:0] wdata;

  // A valid halt kills every younger lane in the same group.
  always_comb begin
    squash  = 1'b0;
    laneVld = '0;
    rawWen  = '0;
    haltHit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      laneVld[i] = bus.in_valid[i] & ~squash;
      squash     = squash | (bus.in_valid[i] & bus.in_halt[i]);
      rawWen[i]  = laneVld[i] & bus.in_regwen[i] & (bus.in_rd[i] != '0);
      haltHit    = haltHit | (laneVld[i] & bus.in_halt[i]);
    end
  end

  // Younger writer to the same register wins; older lane's write is dropped.
  always_comb begin
    laneWen = rawWen;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (rawWen[j] && (bus.in_rd[j] == bus.in_rd[i])) laneWen[i] = 1'b0;
  end

  always_comb begin
    retiredNxt = bus.retired;
    for (int i = 0; i < LANES; i++)
      if (laneVld[i] && (retiredNxt != '1)) retiredNxt = retiredNxt + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST || (!bus.halt && bus.flush)) begin
      bus.out_valid    <= '0;
      bus.out_regwen   <= '0;
      bus.out_equal    <= '0;
      bus.out_memtoreg <= '0;
      bus.out_rd       <= '0;
      bus.out_portb    <= '0;
      bus.out_npc      <= '0;
      bus.out_aluout   <= '0;
      bus.out_load     <= '0;
      if (RST) begin
        bus.halt    <= 1'b0;
        bus.retired <= '0;
      end
    end else if (!bus.halt && bus.en) begin
      bus.out_valid    <= laneVld;
      bus.out_regwen   <= laneWen;
      bus.out_equal    <= bus.in_equal;
      bus.out_memtoreg <= bus.in_memtoreg;
      bus.out_rd       <= bus.in_rd;
      bus.out_portb    <= bus.in_portb;
      bus.out_npc      <= bus.in_npc;
      bus.out_aluout   <= bus.in_aluout;
      bus.out_load     <= bus.in_load;
      bus.halt         <= haltHit;
      bus.retired      <= retiredNxt;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gLane
    mmwb_wb_mux #(.WORD_W(WORD_W), .MTR_W(MTR_W)) uMux (
      .sel    (bus.out_memtoreg[g]),
      .aluout (bus.out_aluout[g]),
      .load   (bus.out_load[g]),
      .npc    (bus.out_npc[g]),
      .portb  (bus.out_portb[g]),
      .wdata  (wdata[g])
    );
  end

  assign bus.out_wdata = wdata;
endmodule
